// File: rtl/fb_scan_reader.sv
// Frame-buffer scan-out reader: video timing to BRAM addresses,
// with V/H flip, read-latency compensation and RGB565->888 expansion.
module fb_scan_reader #(
  parameter int HSIZE     = 640,
  parameter int VSIZE     = 480,
  parameter int ADDR_W    = 18,
  parameter int BASE_ADDR = 0,
  parameter int RD_LAT    = 1
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              Vsync,
  input  logic              Hsync,
  input  logic              DE,
  input  logic              Vflip,
  input  logic              Hflip,
  output logic [ADDR_W-1:0] BRAMADDR,
  output logic              BRAMEN,
  input  logic [15:0]       BRAMDATA,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B,
  output logic              Vsync_o,
  output logic              Hsync_o,
  output logic              DE_o,
  output logic              err
);

  localparam int D  = RD_LAT + 1;
  localparam int PW = $clog2(HSIZE + 1);
  localparam int LW = $clog2(VSIZE + 1);

  localparam logic [ADDR_W-1:0] ROW_FIRST = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ROW_LAST  =
    ADDR_W'(BASE_ADDR + (VSIZE - 1) * HSIZE);
  localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(HSIZE);
  localparam logic [ADDR_W-1:0] COL_LAST  = ADDR_W'(HSIZE - 1);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [PW-1:0]     PIX_END   = PW'(HSIZE);
  localparam logic [LW-1:0]     LINE_END  = LW'(VSIZE);

  localparam logic [0:0] S_WAIT = 1'b0;
  localparam logic [0:0] S_ACT  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              vs_prev_q, de_prev_q;
  logic              vf_q, vf_d;
  logic              hf_q, hf_d;
  logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [LW-1:0]     line_cnt_q, line_cnt_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] col_q, col_d;
  logic              err_q, err_d;

  logic [D-1:0]      vs_sr_q, hs_sr_q, de_sr_q;
  logic [RD_LAT-1:0] v_sr_q;
  logic [7:0]        r_q, g_q, b_q;

  logic active, frame_start, de_fall;
  logic pix_ok, line_ok, excess;

  assign active      = (state_q == S_ACT);
  assign frame_start = vs_prev_q & ~Vsync;
  assign de_fall     = de_prev_q & ~DE;
  assign pix_ok      = (pix_cnt_q < PIX_END);
  assign line_ok     = (line_cnt_q < LINE_END);

  assign BRAMEN   = DE & active & ~frame_start & pix_ok & line_ok;
  assign excess   = DE & active & ~frame_start & ~(pix_ok & line_ok);
  assign BRAMADDR = row_base_q + col_q;

  // Scan state: frame restart, pixel/line stepping and error tracking
  always_comb begin
    state_d    = state_q;
    vf_d       = vf_q;
    hf_d       = hf_q;
    pix_cnt_d  = pix_cnt_q;
    line_cnt_d = line_cnt_q;
    row_base_d = row_base_q;
    col_d      = col_q;
    err_d      = err_q;
    if (frame_start) begin
      state_d    = S_ACT;
      vf_d       = Vflip;
      hf_d       = Hflip;
      pix_cnt_d  = '0;
      line_cnt_d = '0;
      row_base_d = Vflip ? ROW_LAST : ROW_FIRST;
      col_d      = Hflip ? COL_LAST : '0;
      if (active && (line_cnt_q != LINE_END))
        err_d = 1'b1;
    end else if (active) begin
      if (BRAMEN) begin
        pix_cnt_d = pix_cnt_q + PW'(1);
        col_d     = hf_q ? (col_q - ONE_A) : (col_q + ONE_A);
      end
      if (excess)
        err_d = 1'b1;
      if (de_fall) begin
        if (line_ok) begin
          row_base_d = vf_q ? (row_base_q - ROW_STEP)
                            : (row_base_q + ROW_STEP);
          line_cnt_d = line_cnt_q + LW'(1);
        end
        pix_cnt_d = '0;
        col_d     = hf_q ? COL_LAST : '0;
        if (pix_cnt_q != PIX_END)
          err_d = 1'b1;
      end
    end
  end

  // Scan state registers; Vsync history starts low so a frame start
  // needs a genuine high-to-low transition seen after reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_WAIT;
      vs_prev_q  <= 1'b0;
      de_prev_q  <= 1'b0;
      vf_q       <= 1'b0;
      hf_q       <= 1'b0;
      pix_cnt_q  <= '0;
      line_cnt_q <= '0;
      row_base_q <= ROW_FIRST;
      col_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vs_prev_q  <= Vsync;
      de_prev_q  <= DE;
      vf_q       <= vf_d;
      hf_q       <= hf_d;
      pix_cnt_q  <= pix_cnt_d;
      line_cnt_q <= line_cnt_d;
      row_base_q <= row_base_d;
      col_q      <= col_d;
      err_q      <= err_d;
    end
  end

  // Timing delay line and colour register, aligned to read latency
  always_ff @(posedge CLK) begin
    if (RESET) begin
      vs_sr_q <= '1;
      hs_sr_q <= '1;
      de_sr_q <= '0;
      v_sr_q  <= '0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      vs_sr_q <= {vs_sr_q[D-2:0], Vsync};
      hs_sr_q <= {hs_sr_q[D-2:0], Hsync};
      de_sr_q <= {de_sr_q[D-2:0], DE};
      v_sr_q  <= (v_sr_q << 1) | RD_LAT'(BRAMEN);
      if (v_sr_q[RD_LAT-1]) begin
        r_q <= {BRAMDATA[15:11], BRAMDATA[15:13]};
        g_q <= {BRAMDATA[10:5], BRAMDATA[10:9]};
        b_q <= {BRAMDATA[4:0], BRAMDATA[4:2]};
      end else begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end
    end
  end

  assign R       = r_q;
  assign G       = g_q;
  assign B       = b_q;
  assign Vsync_o = vs_sr_q[D-1];
  assign Hsync_o = hs_sr_q[D-1];
  assign DE_o    = de_sr_q[D-1];
  assign err     = err_q;

endmodule

// File: tb/tb_fb_scan_reader.sv
// Directed bench for fb_scan_reader: 8x4 frame at base 0x100,
// one instance with read latency 1 and one with latency 3.
module tb_fb_scan_reader;

  logic        CLK = 1'b0;
  logic        RESET, Vsync, Hsync, DE, Vflip, Hflip;
  logic [17:0] addr1, addr3;
  logic        en1, en3;
  logic [15:0] d1, d3;
  logic [7:0]  r1, g1, b1, r3, g3, b3;
  logic        vo1, ho1, deo1, err1;
  logic        vo3, ho3, deo3, err3;

  int checks = 0;
  int errors = 0;

  logic        ovr;
  logic [15:0] ovr_dat;
  logic [23:0] ovr_rgb;
  logic        exp_err;
  logic        colour;

  logic        hv [0:4];
  logic        hh [0:4];
  logic        hd [0:4];
  logic [23:0] hrgb [0:4];

  logic [15:0] p0, p1, p2;

  localparam logic [15:0] CD [4] =
    '{16'hFFFF, 16'hF800, 16'h0841, 16'h07E0};
  localparam logic [23:0] CR [4] =
    '{24'hFFFFFF, 24'hFF0000, 24'h080808, 24'h00FF00};

  always #5 CLK = ~CLK;

  fb_scan_reader #(
    .HSIZE(8), .VSIZE(4), .ADDR_W(18),
    .BASE_ADDR(32'h100), .RD_LAT(1)
  ) u1 (
    .CLK(CLK), .RESET(RESET),
    .Vsync(Vsync), .Hsync(Hsync), .DE(DE),
    .Vflip(Vflip), .Hflip(Hflip),
    .BRAMADDR(addr1), .BRAMEN(en1), .BRAMDATA(d1),
    .R(r1), .G(g1), .B(b1),
    .Vsync_o(vo1), .Hsync_o(ho1), .DE_o(deo1),
    .err(err1)
  );

  fb_scan_reader #(
    .HSIZE(8), .VSIZE(4), .ADDR_W(18),
    .BASE_ADDR(32'h100), .RD_LAT(3)
  ) u3 (
    .CLK(CLK), .RESET(RESET),
    .Vsync(Vsync), .Hsync(Hsync), .DE(DE),
    .Vflip(Vflip), .Hflip(Hflip),
    .BRAMADDR(addr3), .BRAMEN(en3), .BRAMDATA(d3),
    .R(r3), .G(g3), .B(b3),
    .Vsync_o(vo3), .Hsync_o(ho3), .DE_o(deo3),
    .err(err3)
  );

  function automatic logic [15:0] pat(input logic [17:0] a);
    return {a[7:0], ~a[7:0]};
  endfunction

  function automatic logic [23:0] x565(input logic [15:0] d);
    return {d[15:11], d[15:13], d[10:5], d[10:9],
            d[4:0], d[4:2]};
  endfunction

  // BRAM models: latency 1 and latency 3
  always @(posedge CLK) begin
    d1 <= ovr ? ovr_dat : pat(addr1);
    p0 <= ovr ? ovr_dat : pat(addr3);
    p1 <= p0;
    p2 <= p1;
  end
  assign d3 = p2;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] ev);
    checks++;
    assert (obs === ev) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ev);
    end
  endtask

  task automatic hclr();
    for (int i = 0; i < 5; i++) begin
      hv[i] = 1'b1;
      hh[i] = 1'b1;
      hd[i] = 1'b0;
      hrgb[i] = '0;
    end
  endtask

  task automatic cyc(input logic vs, hs, de, en,
                     input logic [17:0] a,
                     input logic rst, seterr);
    logic [23:0] rgb;
    Vsync = vs;
    Hsync = hs;
    DE = de;
    RESET = rst;
    #1;
    if (!rst) begin
      chk("bramen1", 32'(en1), 32'(en));
      chk("bramen3", 32'(en3), 32'(en));
    end
    if (en) begin
      chk("addr1", 32'(addr1), 32'(a));
      chk("addr3", 32'(addr3), 32'(a));
    end
    chk("err1", 32'(err1), 32'(exp_err));
    chk("err3", 32'(err3), 32'(exp_err));
    for (int i = 4; i > 0; i--) begin
      hv[i] = hv[i-1];
      hh[i] = hh[i-1];
      hd[i] = hd[i-1];
      hrgb[i] = hrgb[i-1];
    end
    rgb = '0;
    if (en) rgb = ovr ? ovr_rgb : x565(pat(a));
    hv[0] = vs;
    hh[0] = hs;
    hd[0] = de;
    hrgb[0] = rgb;
    chk("vs_o1", 32'(vo1), 32'(hv[2]));
    chk("hs_o1", 32'(ho1), 32'(hh[2]));
    chk("de_o1", 32'(deo1), 32'(hd[2]));
    chk("rgb1", 32'({r1, g1, b1}), 32'(hrgb[2]));
    chk("vs_o3", 32'(vo3), 32'(hv[4]));
    chk("hs_o3", 32'(ho3), 32'(hh[4]));
    chk("de_o3", 32'(deo3), 32'(hd[4]));
    chk("rgb3", 32'({r3, g3, b3}), 32'(hrgb[4]));
    if (rst) begin
      hclr();
      exp_err = 1'b0;
    end else if (seterr) begin
      exp_err = 1'b1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1, 1, 0, 0, '0, 0, 0);
  endtask

  task automatic frame(input logic vf, hf,
                       input int l0pix,
                       input int rst_l, rst_p,
                       input logic tog);
    logic        dead;
    logic        en, rst;
    logic [17:0] a;
    int          n;
    dead = 1'b0;
    Vflip = vf;
    Hflip = hf;
    idle(1);
    cyc(0, 1, 0, 0, '0, 0, 0);
    cyc(0, 1, 0, 0, '0, 0, 0);
    idle(1);
    for (int l = 0; l < 4; l++) begin
      if (tog && l == 2) begin
        Vflip = ~vf;
        Hflip = ~hf;
      end
      cyc(1, 0, 0, 0, '0, 0, 0);
      idle(1);
      n = (l == 0) ? l0pix : 8;
      for (int p = 0; p < n; p++) begin
        en = !dead && (p < 8);
        a = vf ? 18'(32'h100 + (3 - l) * 8)
               : 18'(32'h100 + l * 8);
        a = hf ? a + 18'(7 - p) : a + 18'(p);
        rst = (l == rst_l) && (p == rst_p);
        ovr = colour && (l == 1) && (p < 4);
        if (ovr) begin
          ovr_dat = CD[p];
          ovr_rgb = CR[p];
        end
        cyc(1, 1, 1, en, a, rst, !dead && (p >= 8));
        ovr = 1'b0;
        if (rst) dead = 1'b1;
      end
      idle(2);
    end
    idle(2);
  endtask

  initial begin
    RESET = 1'b1;
    Vsync = 1'b1;
    Hsync = 1'b1;
    DE = 1'b0;
    Vflip = 1'b0;
    Hflip = 1'b0;
    ovr = 1'b0;
    ovr_dat = '0;
    ovr_rgb = '0;
    exp_err = 1'b0;
    colour = 1'b0;
    hclr();
    @(posedge CLK);
    #1;
    cyc(1, 1, 0, 0, '0, 1, 0);
    cyc(1, 1, 0, 0, '0, 1, 0);
    chk("rst_addr1", 32'(addr1), 32'h100);
    chk("rst_addr3", 32'(addr3), 32'h100);
    chk("rst_en1", 32'(en1), 32'h0);
    chk("rst_rgb1", 32'({r1, g1, b1}), 32'h0);
    chk("rst_deo1", 32'(deo1), 32'h0);
    chk("rst_vso1", 32'(vo1), 32'h1);
    chk("rst_hso3", 32'(ho3), 32'h1);
    chk("rst_err1", 32'(err1), 32'h0);
    idle(2);

    colour = 1'b1;
    frame(0, 0, 8, -1, -1, 0);
    colour = 1'b0;
    chk("err_plain", 32'(err1), 32'h0);

    frame(1, 1, 8, -1, -1, 1);
    chk("err_flip", 32'(err1), 32'h0);

    frame(0, 0, 10, -1, -1, 0);
    chk("err_excess", 32'(err1), 32'h1);

    frame(1, 0, 8, -1, -1, 0);
    chk("err_sticky", 32'(err1), 32'h1);
    chk("err_sticky3", 32'(err3), 32'h1);

    frame(0, 0, 8, 2, 5, 0);
    idle(3);
    chk("err_cleared", 32'(err1), 32'h0);
    chk("addr_after_rst", 32'(addr1), 32'h100);

    frame(0, 0, 8, -1, -1, 0);
    chk("err_final", 32'(err1), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
